// File: rtl/datagram_serial_tx.sv
// datagram_serial_tx
// Transmit end of the core-to-display datagram link. One parallel datagram is
// accepted from the game core and sent on a single wire. Each frame is a START
// bit, an 8-bit sync header, the payload LSB-first, an even-parity bit and
// STOP_BITS idle-high stop bits. Every bit lasts CLKS_PER_BIT clocks.
//
// Handshake (valid/ready): the transfer happens at a rising clk edge where
// send_valid and send_ready are both 1. datagram is sampled only at that edge.
// send_ready is a registered output that does not depend on send_valid. It
// drops at the accept edge and returns high at the edge that ends the last
// STOP bit. At that same edge frame_done pulses, so a held send_valid is
// accepted at the next edge. send_valid while busy is ignored.

module datagram_serial_tx #(
    parameter int         MSG_WIDTH    = 16,
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         STOP_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSG_WIDTH-1:0] datagram,
    input  logic                 send_valid,
    output logic                 send_ready,
    output logic                 tx_line,
    output logic                 frame_done,
    output logic                 tx_busy,
    output logic [2:0]           state_dbg
);

    // The clock counter runs from 0 to CLKS_PER_BIT-1. The bit index counter
    // must hold the last payload index, the last header index (7) and the
    // last stop-bit index. Its width is the widest of the three.
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW_MSG = $clog2(MSG_WIDTH) + 1;
    localparam int BW_STP = $clog2(STOP_BITS) + 1;
    localparam int BW_A   = (BW_MSG > 4) ? BW_MSG : 4;
    localparam int BW     = (BW_A > BW_STP) ? BW_A : BW_STP;

    localparam logic [CW-1:0] CLK_LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_HDR_LAST  = BW'(7);
    localparam logic [BW-1:0] BIT_MSG_LAST  = BW'(MSG_WIDTH - 1);
    localparam logic [BW-1:0] BIT_STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        STOP    = 3'd5
    } tx_state_t;

    tx_state_t            state,   state_n;
    logic [CW-1:0]        clk_cnt, clk_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [MSG_WIDTH-1:0] shift,   shift_n;
    logic                 parity,  par_n;
    logic                 tx_n;
    logic                 done_n;
    logic                 ready_n;
    logic                 busy_n;
    logic                 bit_wrap;

    // The current serial bit has been held for its full CLKS_PER_BIT clocks.
    assign bit_wrap  = (clk_cnt == CLK_LAST);
    assign state_dbg = state;

    // Register the state, the counters, the datapath and all outputs. Reset
    // aborts a frame at once and drives the line idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tx_line    <= 1'b1;
            frame_done <= 1'b0;
            send_ready <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            parity     <= par_n;
            tx_line    <= tx_n;
            frame_done <= done_n;
            send_ready <= ready_n;
            tx_busy    <= busy_n;
        end
    end

    // Compute the next state and the next value of each registered output.
    // The line value for a new bit is set at the same edge the bit starts.
    always_comb begin
        state_n = state;
        clk_n   = clk_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = parity;
        tx_n    = tx_line;
        done_n  = 1'b0;
        ready_n = send_ready;

        if (state != IDLE) begin
            clk_n = bit_wrap ? '0 : clk_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (send_valid) begin
                    state_n = START;
                    shift_n = datagram;
                    par_n   = 1'b0;
                    clk_n   = '0;
                    bit_n   = '0;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
                end
            end

            START: begin
                if (bit_wrap) begin
                    state_n = HEADER;
                    bit_n   = '0;
                    tx_n    = SYNC_BYTE[0];
                end
            end

            HEADER: begin
                if (bit_wrap) begin
                    if (bit_cnt == BIT_HDR_LAST) begin
                        state_n = PAYLOAD;
                        bit_n   = '0;
                        tx_n    = shift[0];
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        tx_n  = SYNC_BYTE[bit_cnt[2:0] + 3'd1];
                    end
                end
            end

            PAYLOAD: begin
                if (bit_wrap) begin
                    // The bit just finished is shift[0]. Add it to the
                    // parity and move the next payload bit into place.
                    par_n   = parity ^ shift[0];
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_MSG_LAST) begin
                        state_n = PARITY;
                        bit_n   = '0;
                        tx_n    = parity ^ shift[0];
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        tx_n  = shift[1];
                    end
                end
            end

            PARITY: begin
                if (bit_wrap) begin
                    state_n = STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (bit_wrap) begin
                    if (bit_cnt == BIT_STOP_LAST) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                clk_n   = '0;
                bit_n   = '0;
                tx_n    = 1'b1;
                ready_n = 1'b1;
            end
        endcase

        busy_n = ~ready_n;
    end

endmodule

// File: tb/tb_datagram_serial_tx.sv
// Bench for datagram_serial_tx. Instance 0 uses 4 clocks per bit. Instance 1
// uses 2 clocks per bit. Both carry 16-bit payloads. The expected waveform is
// built from the frame layout. A loopback receiver samples each bit in its
// middle and rebuilds the datagram.

module tb_datagram_serial_tx;

    localparam int          MSGW = 16;
    localparam int          STOPB = 2;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic            clk;
    logic [1:0]      rst_v;
    logic [1:0]      valid_v;
    logic [MSGW-1:0] dg_v [2];
    logic [1:0]      ready_v;
    logic [1:0]      tx_v;
    logic [1:0]      done_v;
    logic [1:0]      busy_v;
    logic [2:0]      st_a;
    logic [2:0]      st_b;

    int n_total;
    int n_pass;
    int n_fail;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    datagram_serial_tx #(
        .MSG_WIDTH(MSGW), .CLKS_PER_BIT(4), .SYNC_BYTE(SYNC), .STOP_BITS(STOPB)
    ) dut_a (
        .clk(clk), .rst(rst_v[0]), .datagram(dg_v[0]), .send_valid(valid_v[0]),
        .send_ready(ready_v[0]), .tx_line(tx_v[0]), .frame_done(done_v[0]),
        .tx_busy(busy_v[0]), .state_dbg(st_a)
    );

    datagram_serial_tx #(
        .MSG_WIDTH(MSGW), .CLKS_PER_BIT(2), .SYNC_BYTE(SYNC), .STOP_BITS(STOPB)
    ) dut_b (
        .clk(clk), .rst(rst_v[1]), .datagram(dg_v[1]), .send_valid(valid_v[1]),
        .send_ready(ready_v[1]), .tx_line(tx_v[1]), .frame_done(done_v[1]),
        .tx_busy(busy_v[1]), .state_dbg(st_b)
    );

    // scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference frame: START, header LSB-first, payload LSB-first, even parity, stops.
    task automatic build_frame(input logic [MSGW-1:0] d, output bit fr[$]);
        logic [7:0] hdr;
        hdr = SYNC;
        fr = {};
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(hdr[i]);
        for (int i = 0; i < MSGW; i++) fr.push_back(d[i]);
        fr.push_back($countones(d) % 2 == 1);
        for (int i = 0; i < STOPB; i++) fr.push_back(1'b1);
    endtask

    // driver
    task automatic drive(input int sel, input logic v, input logic [MSGW-1:0] d);
        valid_v[sel] = v;
        dg_v[sel]    = d;
    endtask

    // Present d, wait for the accept, then check every cycle of the frame.
    // Returns at the negedge after the frame_done edge. If abort_at >= 0,
    // reset is pulsed at that cycle of the frame instead.
    task automatic run_frame(input int sel, input logic [MSGW-1:0] d, input bit keep_valid,
                             input logic [MSGW-1:0] nd, input int abort_at, output int waits);
        int cpb;
        int len;
        bit fr[$];
        bit rx[$];
        logic [7:0] hdr;
        logic [MSGW-1:0] dec;
        cpb = (sel == 0) ? 4 : 2;
        build_frame(d, fr);
        len = fr.size() * cpb;
        rx = {};
        drive(sel, 1'b1, d);
        waits = 0;
        while (ready_v[sel] !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait_bound", 32'(waits < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, keep_valid, nd);
        for (int k = 0; k <= len; k++) begin
            if (k == abort_at) begin
                rst_v[sel] = 1'b0;
                #1;
                check("abort_tx_line", 32'(tx_v[sel]), 32'd1);
                check("abort_ready", 32'(ready_v[sel]), 32'd1);
                check("abort_busy", 32'(busy_v[sel]), 32'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done_v[sel]), 32'd0);
                    check("abort_tx_idle", 32'(tx_v[sel]), 32'd1);
                end
                rst_v[sel] = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("post_abort_no_done", 32'(done_v[sel]), 32'd0);
                    check("post_abort_ready", 32'(ready_v[sel]), 32'd1);
                end
                return;
            end
            if (k < len) begin
                check($sformatf("tx_line_c%0d", k), 32'(tx_v[sel]), 32'(fr[k / cpb]));
                check("ready_busy_frame", 32'(ready_v[sel]), 32'd0);
                check("busy_in_frame", 32'(busy_v[sel]), 32'd1);
                check("done_in_frame", 32'(done_v[sel]), 32'd0);
                if ((k % cpb) == cpb / 2) rx.push_back(tx_v[sel]);
                @(negedge clk);
            end else begin
                check("frame_done_at_end", 32'(done_v[sel]), 32'd1);
                check("ready_at_end", 32'(ready_v[sel]), 32'd1);
                check("busy_at_end", 32'(busy_v[sel]), 32'd0);
                check("tx_idle_at_end", 32'(tx_v[sel]), 32'd1);
            end
        end
        // loopback receiver
        check("rx_bit_count", 32'(rx.size()), 32'(fr.size()));
        if (rx.size() == fr.size()) begin
            for (int i = 0; i < 8; i++) hdr[i] = rx[1 + i];
            for (int i = 0; i < MSGW; i++) dec[i] = rx[9 + i];
            check("rx_start", 32'(rx[0]), 32'd0);
            check("rx_header", 32'(hdr), 32'(SYNC));
            check("rx_datagram", 32'(dec), 32'(d));
            check("rx_even_parity", 32'(($countones(dec) + int'(rx[9 + MSGW])) % 2), 32'd0);
            for (int i = 0; i < STOPB; i++)
                check("rx_stop", 32'(rx[10 + MSGW + i]), 32'd1);
        end
    endtask

    initial begin
        int w;
        int gap;
        logic [MSGW-1:0] r;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_v   = 2'b00;
        valid_v = 2'b00;
        dg_v[0] = '0;
        dg_v[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_line", 32'(tx_v[0]), 32'd1);
        check("reset_ready", 32'(ready_v[0]), 32'd1);
        check("reset_busy", 32'(busy_v[0]), 32'd0);
        check("reset_done", 32'(done_v[0]), 32'd0);
        rst_v = 2'b11;

        // 1: idle with no valid
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx_line", 32'(tx_v[0]), 32'd1);
            check("idle_ready", 32'(ready_v[0]), 32'd1);
            check("idle_done", 32'(done_v[0]), 32'd0);
        end

        // 2: single-bit payload, frame_done after 112 cycles
        run_frame(0, 16'h0001, 1'b0, 16'h0000, -1, w);
        @(negedge clk);
        check("done_one_cycle", 32'(done_v[0]), 32'd0);
        check("idle_after_frame", 32'(tx_v[0]), 32'd1);

        // 3: all ones gives parity 0, datagram changed after accept is not sent
        run_frame(0, 16'hFFFF, 1'b0, 16'h1234, -1, w);
        repeat (2) @(negedge clk);

        // 4: send_valid held, back-to-back frames
        run_frame(0, 16'hBEEF, 1'b1, 16'h0F0F, -1, w);
        run_frame(0, 16'h0F0F, 1'b0, 16'h0000, -1, w);
        check("back_to_back_wait", 32'(w), 32'd0);
        repeat (2) @(negedge clk);

        // 5: reset in the middle of the payload, then a full clean frame
        run_frame(0, 16'hC3A5, 1'b0, 16'h0000, 60, w);
        run_frame(0, 16'h5A3C, 1'b0, 16'h0000, -1, w);
        repeat (2) @(negedge clk);

        // 6: two clocks per bit, random datagrams
        for (int i = 0; i < 100; i++) begin
            r = MSGW'($urandom);
            run_frame(1, r, 1'b0, MSGW'($urandom), -1, w);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
